move_sequencer: RTL and testbench
=================================

# move_sequencer

Queues cube-move codes and issues them one at a time to the `move_to_step` stepper stage, sitting directly upstream of it in `main`. Each move is presented on `next_move` with a single-cycle `move_start` pulse. The sequencer then waits for the stepper's `move_done` handshake before issuing the next move. Producers (solver logic, button/switch entry) push 4-bit move codes into an internal FIFO.

## Interface
- `DEPTH`, 16: FIFO entries, power of two, ≥2.
- `ACK_TIMEOUT`, 64: cycles allowed for `move_done` to fall after `move_start`.
- `SETTLE_CYCLES`, 250000: idle gap between moves (10 ms at 25 MHz); used only with the settle feature.
- `clock`  in  1  system clock (`clock_25mhz`).
- `reset_n`  in  1  asynchronous, active-low reset.
- `move_in`  in  4  move code to enqueue.
- `push`  in  1  enqueue `move_in` this cycle.
- `flush`  in  1  discard all queued moves.
- `pause`  in  1  hold off issuing new moves.
- `move_done`  in  1  stepper idle level: high = idle, low = moving.
- `next_move`  out  4  move code to the stepper.
- `move_start`  out  1  one-cycle start strobe to the stepper.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `count`  out  $clog2(DEPTH)+1  entries queued.
- `busy`  out  1  state ≠ IDLE.
- `error`  out  1  sticky ack-timeout flag.
- `moves_issued`  out  16  completed-move counter, wraps.

## Operation
- Reset values: all outputs 0; FIFO empty; state IDLE.
- FIFO: a push when not full writes at the tail. A push when full is dropped; no state change.
- State machine, all registered:
  - IDLE → LOAD when `count≠0`, `!pause`, `!error`, and `move_done=1`.
  - LOAD: pop the head into `next_move`, then go to ISSUE.
  - ISSUE: drive `move_start=1` for one cycle, clear the ack counter, then go to WAIT_ACK.
  - WAIT_ACK: go to WAIT_DONE when `move_done=0`. If the ack counter reaches `ACK_TIMEOUT`, set `error` and go to IDLE.
  - WAIT_DONE: when `move_done=1`, increment `moves_issued` and go to SETTLE. With the settle feature compiled out, go straight to IDLE.
  - SETTLE: count `SETTLE_CYCLES`, then go to IDLE.
- `next_move` is held stable from LOAD through the end of the move. It changes only in LOAD.
- `count` arithmetic is width `$clog2(DEPTH)+1`. Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- Push and pop in the same cycle: `count` is unchanged. This is legal even when full, because the pop frees the slot.
- `flush` empties the FIFO and clears `error`. An in-flight move is not aborted; the FSM completes WAIT_ACK/WAIT_DONE normally. A `push` in the same cycle as `flush` is dropped.
- `pause` is sampled only in IDLE. A move already in flight finishes.
- `error` blocks issuing until `flush`. The move that timed out is lost and is not counted.
- Asserting `reset_n` at any point, including mid-move, immediately returns everything to reset values.

## Timing
- Push into an empty, idle sequencer at edge N: `count=1` after N, LOAD during N+1, `next_move` valid after N+2, `move_start` high for the cycle after N+2 only.
- `full` and `count` update on the edge following push/pop.
- Minimum back-to-back spacing: 4 cycles plus stepper move time, plus `SETTLE_CYCLES` when the settle feature is enabled.
- `move_done` is treated as synchronous to `clock`; no internal synchronizer.

## Configuration
- `MOVE_SEQ_SETTLE_EN` defined: the SETTLE state and its counter exist; an inter-move gap of `SETTLE_CYCLES` is enforced.
- `MOVE_SEQ_SETTLE_EN` undefined: SETTLE and its counter are removed; WAIT_DONE goes to IDLE directly, and `SETTLE_CYCLES` is ignored.

## Test plan
- Reset, then push 4'h3. Stepper model drops `move_done` 2 cycles after start and holds it low 10 cycles → exactly one `move_start` with `next_move=3`; `moves_issued=1`; `count=0`; `busy=0` at end.
- Push 16 codes 0..F with `pause=1`, then a 17th code → `full=1`, `count=16`, 17th dropped. Release `pause` → issue order 0..F, `moves_issued=16`.
- Stepper model never drops `move_done` → `error=1` after 64 cycles in WAIT_ACK; no further starts. `flush` → `error=0`, `count=0`.
- `flush` while in WAIT_DONE with 5 queued → the current move completes (`moves_issued` +1), no further starts, `count=0`.
- `reset_n` low mid-WAIT_DONE → all outputs 0 immediately; after release, no `move_start` without a new push.
- With `MOVE_SEQ_SETTLE_EN` and `SETTLE_CYCLES=100`, two queued moves → the second `move_start` occurs 103 cycles after `move_done` rises. Without the macro → 3 cycles.

Source files
------------

// File: rtl/move_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : move_sequencer_if                                          |
// | Description : Producer/stepper-side bundle for move_sequencer. The       |
// |               master side pushes codes, controls flush/pause and         |
// |               returns the stepper idle level. The slave side is the      |
// |               sequencer itself.                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface move_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic [3:0]         move_in;
  logic               push;
  logic               flush;
  logic               pause;
  logic               move_done;
  logic [3:0]         next_move;
  logic               move_start;
  logic               full;
  logic [c_cnt_w-1:0] count;
  logic               busy;
  logic               error;
  logic [15:0]        moves_issued;

  modport master (
    output move_in, push, flush, pause, move_done,
    input  next_move, move_start, full, count, busy, error, moves_issued
  );

  modport slave (
    input  move_in, push, flush, pause, move_done,
    output next_move, move_start, full, count, busy, error, moves_issued
  );
endinterface
`default_nettype wire

// File: rtl/move_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : move_sequencer                                             |
// | Description : FIFO of 4-bit cube-move codes feeding the move_to_step     |
// |               stepper one move at a time. Each move is presented on      |
// |               next_move with a one-cycle move_start strobe, then the     |
// |               sequencer waits for move_done to fall (ack) and rise       |
// |               (completion) before issuing the next one.                  |
// | Options     : MOVE_SEQ_SETTLE_EN - adds a SETTLE state that enforces an  |
// |               idle gap of SETTLE_CYCLES between consecutive moves.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module move_sequencer #(
  parameter int DEPTH         = 16,
  parameter int ACK_TIMEOUT   = 64,
  parameter int SETTLE_CYCLES = 250000
) (
  input  wire logic          clock_25mhz,
  input  wire logic          reset_n,
  move_sequencer_if.slave    bus
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_ack_w = $clog2(ACK_TIMEOUT + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);
  localparam logic [c_ack_w-1:0] c_ack_last = c_ack_w'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
`ifdef MOVE_SEQ_SETTLE_EN
    , ST_SETTLE  = 3'd5
`endif
  } state_t;

  // FIFO storage and bookkeeping
  logic [3:0]         r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  // Sequencer state and outputs
  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_next_move;
  logic               r_move_start;
  logic               r_error;
  logic [15:0]        r_moves_issued;
  logic [c_ack_w-1:0] r_ack_cnt;

  // Per-cycle control decoded from the state machine
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr;
  logic w_ack_clr;
  logic w_ack_inc;
  logic w_err_set;
  logic w_done_inc;

  assign w_full  = (r_count == c_cnt_full);
  assign w_empty = (r_count == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // accepted then. Flush always wins over a simultaneous push.
  assign w_wr = bus.push && !bus.flush && (!w_full || w_pop);

`ifdef MOVE_SEQ_SETTLE_EN
  localparam int c_set_w = $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_set_w-1:0] c_set_last = c_set_w'(SETTLE_CYCLES - 1);

  logic [c_set_w-1:0] r_settle_cnt;
  logic               w_settle_clr;
  logic               w_settle_inc;

  // Inter-move gap counter, restarted on entry to SETTLE
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_settle_cnt <= '0;
    end else if (w_settle_clr) begin
      r_settle_cnt <= '0;
    end else if (w_settle_inc) begin
      r_settle_cnt <= r_settle_cnt + 1'b1;
    end
  end
`endif

  // State register
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_ack_clr    = 1'b0;
    w_ack_inc    = 1'b0;
    w_err_set    = 1'b0;
    w_done_inc   = 1'b0;
`ifdef MOVE_SEQ_SETTLE_EN
    w_settle_clr = 1'b0;
    w_settle_inc = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !bus.pause && !r_error && bus.move_done) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A flush on the IDLE->LOAD edge can leave nothing to pop; in that
        // case nothing is issued and the sequencer simply returns to IDLE.
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_ISSUE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_ack_clr    = 1'b1;
        w_state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!bus.move_done) begin
          w_state_next = ST_WAIT_DONE;
        end else if (r_ack_cnt == c_ack_last) begin
          w_err_set    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_ack_inc = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.move_done) begin
          w_done_inc = 1'b1;
`ifdef MOVE_SEQ_SETTLE_EN
          w_settle_clr = 1'b1;
          w_state_next = ST_SETTLE;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
`ifdef MOVE_SEQ_SETTLE_EN
      ST_SETTLE: begin
        if (r_settle_cnt == c_set_last) begin
          w_state_next = ST_IDLE;
        end else begin
          w_settle_inc = 1'b1;
        end
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FIFO data write; storage needs no reset since count gates every read
  always_ff @(posedge clock_25mhz) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.move_in;
    end
  end

  // FIFO pointers and occupancy; flush discards everything queued
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Move presentation: next_move only changes on a pop, strobe follows it
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_next_move  <= 4'h0;
      r_move_start <= 1'b0;
    end else begin
      r_move_start <= w_pop;
      if (w_pop) begin
        r_next_move <= r_mem[r_rd_ptr];
      end
    end
  end

  // Ack watchdog counter, cleared as the strobe goes out
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_cnt <= '0;
    end else if (w_ack_clr) begin
      r_ack_cnt <= '0;
    end else if (w_ack_inc) begin
      r_ack_cnt <= r_ack_cnt + 1'b1;
    end
  end

  // Sticky timeout flag; an explicit flush takes priority over a new timeout
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_error <= 1'b0;
    end else if (bus.flush) begin
      r_error <= 1'b0;
    end else if (w_err_set) begin
      r_error <= 1'b1;
    end
  end

  // Completed-move counter, free-running wrap
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_moves_issued <= 16'h0000;
    end else if (w_done_inc) begin
      r_moves_issued <= r_moves_issued + 16'h0001;
    end
  end

  assign bus.next_move    = r_next_move;
  assign bus.move_start   = r_move_start;
  assign bus.full         = w_full;
  assign bus.count        = r_count;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.error        = r_error;
  assign bus.moves_issued = r_moves_issued;

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_move_sequencer                                          |
// | Description : Directed self-checking bench for move_sequencer with a     |
// |               behavioural stepper and an issue-order scoreboard.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_move_sequencer;

  localparam int DEPTH = 16;
`ifdef MOVE_SEQ_SETTLE_EN
  localparam int EXP_GAP = 103;
`else
  localparam int EXP_GAP = 3;
`endif

  logic clk;
  logic rst_n;

  move_sequencer_if #(.DEPTH(DEPTH)) bus ();

  move_sequencer #(
    .DEPTH         (DEPTH),
    .ACK_TIMEOUT   (64),
    .SETTLE_CYCLES (100)
  ) dut (
    .clock_25mhz (clk),
    .reset_n     (rst_n),
    .bus         (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];

  // Stepper model / monitor state
  int         cyc = 0;
  int         ph = 0;
  int         scnt = 0;
  int         step_mode = 0;
  int         n_starts = 0;
  int         last_start = 0;
  int         last_rise = 0;
  int         last_gap = 0;
  logic [3:0] exp_code;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stepper model: drops move_done 2 cycles after a start, low for 10
  // cycles (or never drops in step_mode 1); scoreboards each start.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (!rst_n) begin
      ph            = 0;
      scnt          = 0;
      bus.move_done = 1'b1;
    end else begin
      if (ph == 1) begin
        scnt++;
        if (scnt == 2) begin
          bus.move_done = 1'b0;
          ph            = 2;
          scnt          = 0;
        end
      end else if (ph == 2) begin
        scnt++;
        if (scnt == 10) begin
          bus.move_done = 1'b1;
          ph            = 0;
          last_rise     = cyc;
        end
      end
      if (bus.move_start === 1'b1) begin
        n_starts++;
        last_gap   = cyc - last_rise;
        last_start = cyc;
        check("start_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_code = exp_q.pop_front();
          check("issue_order", 32'(bus.next_move), 32'(exp_code));
        end
        if (step_mode == 0) begin
          ph   = 1;
          scnt = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_push(input logic [3:0] code, input bit expect_issue);
    bus.move_in = code;
    bus.push    = 1'b1;
    if (expect_issue) exp_q.push_back(code);
    tick(1);
    bus.push = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!bus.busy && bus.count == '0 && ph == 0) break;
      tick(1);
    end
    check("drain_in_budget", 32'(i < budget), 32'd1);
  endtask

  task automatic wait_move_low(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.move_done === 1'b0) break;
      tick(1);
    end
    check("move_done_low_seen", 32'(bus.move_done), 32'd0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_next_move"},    32'(bus.next_move),    32'd0);
    check({pfx, "_move_start"},   32'(bus.move_start),   32'd0);
    check({pfx, "_full"},         32'(bus.full),         32'd0);
    check({pfx, "_count"},        32'(bus.count),        32'd0);
    check({pfx, "_busy"},         32'(bus.busy),         32'd0);
    check({pfx, "_error"},        32'(bus.error),        32'd0);
    check({pfx, "_moves_issued"}, 32'(bus.moves_issued), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int i;
    rst_n       = 1'b0;
    bus.move_in = 4'h0;
    bus.push    = 1'b0;
    bus.flush   = 1'b0;
    bus.pause   = 1'b0;

    // Reset state
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Single move with first-move latency
    do_push(4'h3, 1'b1);
    check("t1_count_after_push", 32'(bus.count), 32'd1);
    tick(1);
    check("t1_busy_in_load", 32'(bus.busy), 32'd1);
    tick(1);
    check("t1_start_high", 32'(bus.move_start), 32'd1);
    check("t1_next_move", 32'(bus.next_move), 32'h3);
    tick(1);
    check("t1_start_one_cycle", 32'(bus.move_start), 32'd0);
    wait_drain(100);
    check("t1_starts", 32'(n_starts), 32'd1);
    check("t1_moves_issued", 32'(bus.moves_issued), 32'd1);
    check("t1_count_end", 32'(bus.count), 32'd0);
    check("t1_busy_end", 32'(bus.busy), 32'd0);
    check("t1_next_move_held", 32'(bus.next_move), 32'h3);

    // Fill while paused, overflow drop, push+pop while full
    bus.pause = 1'b1;
    for (int k = 0; k < 16; k++) do_push(4'(k), 1'b1);
    check("t2_full", 32'(bus.full), 32'd1);
    check("t2_count16", 32'(bus.count), 32'd16);
    do_push(4'h7, 1'b0);
    check("t2_overflow_count", 32'(bus.count), 32'd16);
    check("t2_no_start_paused", 32'(n_starts), 32'd1);
    bus.pause = 1'b0;
    tick(1);
    check("t2_load_busy", 32'(bus.busy), 32'd1);
    do_push(4'hA, 1'b1);
    check("t2_pushpop_full_count", 32'(bus.count), 32'd16);
    check("t2_pushpop_full_flag", 32'(bus.full), 32'd1);
    wait_drain(1500);
    check("t2_moves_issued", 32'(bus.moves_issued), 32'd18);
    check("t2_starts", 32'(n_starts), 32'd18);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Ack timeout: stepper never acknowledges
    step_mode = 1;
    s0 = n_starts;
    do_push(4'h5, 1'b1);
    for (i = 0; i < 300; i++) begin
      if (bus.error === 1'b1) break;
      tick(1);
    end
    check("t3_error_set", 32'(bus.error), 32'd1);
    check("t3_timeout_cycles", 32'(cyc - last_start), 32'd65);
    check("t3_busy_after_timeout", 32'(bus.busy), 32'd0);
    do_push(4'h6, 1'b0);
    tick(20);
    check("t3_no_start_in_error", 32'(n_starts), 32'(s0 + 1));
    check("t3_count_blocked", 32'(bus.count), 32'd1);
    check("t3_timeout_not_counted", 32'(bus.moves_issued), 32'd18);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    check("t3_flush_error", 32'(bus.error), 32'd0);
    check("t3_flush_count", 32'(bus.count), 32'd0);
    step_mode = 0;
    tick(5);
    check("t3_idle_after_flush", 32'(n_starts), 32'(s0 + 1));

    // Flush during WAIT_DONE with 5 queued (and a push dropped by flush)
    s0 = n_starts;
    bus.pause = 1'b1;
    do_push(4'hB, 1'b1);
    for (int k = 1; k <= 5; k++) do_push(4'(k), 1'b0);
    bus.pause = 1'b0;
    wait_move_low(50);
    tick(2);
    check("t4_queued5", 32'(bus.count), 32'd5);
    bus.flush   = 1'b1;
    bus.push    = 1'b1;
    bus.move_in = 4'hC;
    tick(1);
    bus.flush = 1'b0;
    bus.push  = 1'b0;
    check("t4_flushed_count", 32'(bus.count), 32'd0);
    wait_drain(100);
    tick(10);
    check("t4_moves_issued", 32'(bus.moves_issued), 32'd19);
    check("t4_one_start", 32'(n_starts), 32'(s0 + 1));

    // Reset mid-WAIT_DONE
    s0 = n_starts;
    do_push(4'h9, 1'b1);
    wait_move_low(50);
    tick(2);
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("t5_no_restart", 32'(n_starts), 32'(s0 + 1));
    check("t5_idle", 32'(bus.busy), 32'd0);

    // Back-to-back spacing after move_done rises
    bus.pause = 1'b1;
    do_push(4'h1, 1'b1);
    do_push(4'h2, 1'b1);
    bus.pause = 1'b0;
    wait_drain(2000);
    check("t6_gap", 32'(last_gap), 32'(EXP_GAP));
    check("t6_moves_issued", 32'(bus.moves_issued), 32'd2);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
